seq_divider: RTL and testbench

- Iterative signed 32-bit divider; the inverse-direction counterpart to the datapath's multiply unit.
- Fills the DIV slot of the ALU: quotient drives ResultLo, remainder drives ResultHi.
- Multi-cycle with a start/done handshake, so the control unit stalls on busy instead of waiting a fixed number of cycles.
- Restoring shift-subtract on operand magnitudes, followed by a sign-correction cycle.

---
 rtl/seq_divider.sv | 115 +++++++++++
 tb/tb_seq_divider.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative signed divider: restoring shift-subtract on magnitudes,
// then one sign-correction cycle. Quotient to ResultLo, remainder to ResultHi.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] RA,
  input  logic [WIDTH-1:0] RB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] divd;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    count;
  logic             sign_q;
  logic             sign_r;
  logic             dbz;

  logic [WIDTH-1:0] ra_mag;
  logic [WIDTH-1:0] rb_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // Unsigned magnitude: -2^(WIDTH-1) maps exactly to 2^(WIDTH-1)
  always_comb begin
    ra_mag  = RA[WIDTH-1] ? -RA : RA;
    rb_mag  = RB[WIDTH-1] ? -RB : RB;
    shifted = {rem, divd[WIDTH-1]};
    diff    = shifted - {1'b0, dvsr};
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state       <= IDLE;
      divd        <= '0;
      dvsr        <= '0;
      rem         <= '0;
      count       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dbz         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sign_q <= RA[WIDTH-1] ^ RB[WIDTH-1];
            sign_r <= RA[WIDTH-1];
            dvsr   <= rb_mag;
            rem    <= '0;
            count  <= '0;
            busy   <= 1'b1;
            if (RB == '0) begin
              // raw dividend is returned as the remainder
              dbz   <= 1'b1;
              divd  <= RA;
              state <= FIX;
            end else begin
              dbz   <= 1'b0;
              divd  <= ra_mag;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (!diff[WIDTH]) begin
            rem  <= diff[WIDTH-1:0];
            divd <= {divd[WIDTH-2:0], 1'b1};
          end else begin
            rem  <= shifted[WIDTH-1:0];
            divd <= {divd[WIDTH-2:0], 1'b0};
          end
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (dbz) begin
            quotient  <= '1;
            remainder <= divd;
          end else begin
            quotient  <= sign_q ? -divd : divd;
            remainder <= sign_r ? -rem : rem;
          end
          div_by_zero <= dbz;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed vectors with
// hand-computed results, monitor pops on each done pulse.
module tb_seq_divider;

  logic        clock;
  logic        clear;
  logic        start;
  logic [31:0] RA;
  logic [31:0] RB;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  seq_divider #(.WIDTH(32)) dut (
    .clock      (clock),
    .clear      (clear),
    .start      (start),
    .RA         (RA),
    .RB         (RB),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
    int          t0;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending request
  always @(negedge clock) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done at cycle %0d",
                 cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_q"}, quotient, e.q);
        chk({e.name, "_r"}, remainder, e.r);
        chk({e.name, "_dbz"}, {31'b0, div_by_zero}, {31'b0, e.dbz});
        chk({e.name, "_lat"}, 32'(cyc - e.t0), 32'(e.lat));
      end
    end
  end

  task automatic push(input logic [31:0] q, input logic [31:0] r,
                      input logic dbz, input int lat, input string n);
    exp_t e;
    e.q    = q;
    e.r    = r;
    e.dbz  = dbz;
    e.lat  = lat;
    e.t0   = cyc + 1;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (sb.size() == 0 && !busy && !done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got pending=%0d expected 0", n, sb.size());
      sb.delete();
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r,
                       input logic dbz, input int lat, input string n);
    @(negedge clock);
    RA    = a;
    RB    = b;
    start = 1'b1;
    push(q, r, dbz, lat, n);
    @(negedge clock);
    start = 1'b0;
    chk({n, "_busy"}, {31'b0, busy}, 32'd1);
    wait_idle(n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    clear = 1'b1;
    start = 1'b0;
    RA    = '0;
    RB    = '0;
    repeat (3) @(negedge clock);
    chk("rst_q", quotient, 32'h0);
    chk("rst_r", remainder, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    clear = 1'b0;
    @(negedge clock);

    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, "p100_7");
    issue(32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33, "n100_7");
    issue(32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0, 33, "p100_n7");
    issue(32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 1'b0, 33, "n100_n7");
    issue(32'd7, 32'd0, 32'hFFFFFFFF, 32'd7, 1'b1, 1, "dbz7");
    repeat (3) @(negedge clock);
    chk("dbz_hold", {31'b0, div_by_zero}, 32'd1);
    issue(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, "p9_3");
    issue(32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1, "dbzn7");
    issue(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 33, "ovf");
    issue(32'h80000000, 32'd1, 32'h80000000, 32'd0, 1'b0, 33, "min_1");
    issue(32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 33, "zero_5");
    issue(32'd5, 32'd100, 32'd0, 32'd5, 1'b0, 33, "p5_100");

    // Start while busy is ignored; start in done cycle is accepted
    @(negedge clock);
    RA    = 32'd100;
    RB    = 32'd7;
    start = 1'b1;
    push(32'd14, 32'd2, 1'b0, 33, "ign");
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    RA    = 32'd1;
    RB    = 32'd1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ign_done: got no done expected done");
    end
    RA    = 32'hFFFFFFCE;
    RB    = 32'd6;
    start = 1'b1;
    push(32'hFFFFFFF8, 32'hFFFFFFFE, 1'b0, 33, "back2back");
    @(negedge clock);
    start = 1'b0;
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    chk("b2b_done", {31'b0, done}, 32'd0);
    wait_idle("back2back");

    // Asynchronous clear mid-operation
    @(negedge clock);
    RA    = 32'd100;
    RB    = 32'd7;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(posedge clock);
    #2;
    clear = 1'b1;
    #1;
    chk("clr_q", quotient, 32'h0);
    chk("clr_r", remainder, 32'h0);
    chk("clr_busy", {31'b0, busy}, 32'd0);
    chk("clr_done", {31'b0, done}, 32'd0);
    @(negedge clock);
    clear = 1'b0;
    repeat (40) @(negedge clock);
    chk("clr_idle", {31'b0, busy}, 32'd0);
    issue(32'd50, 32'd6, 32'd8, 32'd2, 1'b0, 33, "p50_6");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
